// File: rtl/pe_psum_drain.sv
// Partial-sum drain stage behind the PE matrix: accumulates Bus_P passes into a
// saturating bank, then streams the bank out one row per valid/ready beat.
module pe_psum_drain #(
   parameter int DataWidth = 8,
   parameter int AccWidth  = 24,
   parameter int Rows      = 11,
   parameter int Cols      = 11
) (
   input  logic                                        CLK,
   input  logic                                        RST,
   input  logic                                        cap_valid,
   input  logic                                        cap_last,
   output logic                                        cap_ready,
   input  logic [Rows-1:0][Cols-1:0][2*DataWidth-1:0]  Bus_P,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [Cols-1:0][AccWidth-1:0]               out_row,
   output logic [3:0]                                  out_row_idx,
   output logic                                        out_last,
   output logic                                        sat_flag,
   output logic                                        busy
);

   localparam int         PW      = 2 * DataWidth;
   localparam logic [3:0] LastRow = 4'(Rows - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                                state_q, state_d;
   logic [Rows-1:0][Cols-1:0][AccWidth-1:0] acc_q, acc_d;
   logic                                  first_q, first_d;
   logic [3:0]                            row_q, row_d;
   logic                                  sat_q, sat_d;
   logic                                  out_valid_q;
   logic                                  out_last_q;
   logic                                  busy_q;
   logic                                  cap_ready_q;
   logic                                  capture_s;
   logic                                  sat_any_s;
   logic [AccWidth:0]                     ext_s;
   logic [AccWidth:0]                     sum_s;

   function automatic logic [AccWidth:0] sext_fn(input logic [PW-1:0] v);
      return {{(AccWidth + 1 - PW){v[PW-1]}}, v};
   endfunction

   // Result is {saturated, clamped value}; the add is one bit wider so overflow shows in the top two bits.
   function automatic logic [AccWidth:0] sat_add(input logic [AccWidth-1:0] a,
                                                 input logic [PW-1:0]       b);
      logic [AccWidth:0] sum;
      sum = {a[AccWidth-1], a} + sext_fn(b);
      if (sum[AccWidth] != sum[AccWidth-1]) begin
         if (sum[AccWidth]) begin
            return {1'b1, 1'b1, {(AccWidth - 1){1'b0}}};
         end else begin
            return {1'b1, 1'b0, {(AccWidth - 1){1'b1}}};
         end
      end else begin
         return {1'b0, sum[AccWidth-1:0]};
      end
   endfunction

   // Next-state logic: capture/accumulate in IDLE/ACCUM, row stepping in DRAIN.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      first_d   = first_q;
      row_d     = row_q;
      sat_d     = sat_q;
      sat_any_s = 1'b0;
      ext_s     = '0;
      sum_s     = '0;
      capture_s = cap_valid && (state_q != DRAIN);
      case (state_q)
         IDLE, ACCUM: begin
            if (capture_s) begin
               for (int r = 0; r < Rows; r++) begin
                  for (int c = 0; c < Cols; c++) begin
                     if (first_q) begin
                        ext_s       = sext_fn(Bus_P[r][c]);
                        acc_d[r][c] = ext_s[AccWidth-1:0];
                     end else begin
                        sum_s       = sat_add(acc_q[r][c], Bus_P[r][c]);
                        acc_d[r][c] = sum_s[AccWidth-1:0];
                        sat_any_s   = sat_any_s | sum_s[AccWidth];
                     end
                  end
               end
               first_d = 1'b0;
               sat_d   = first_q ? 1'b0 : (sat_q | sat_any_s);
               if (cap_last) begin
                  state_d = DRAIN;
                  row_d   = 4'd0;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = state_q;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (row_q == LastRow) begin
                  state_d = IDLE;
                  first_d = 1'b1;
                  row_d   = 4'd0;
               end else begin
                  row_d = row_q + 4'd1;
               end
            end else begin
               row_d = row_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, bank and registered status outputs; RST discards any frame in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         first_q     <= 1'b1;
         row_q       <= 4'd0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         cap_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         first_q     <= first_d;
         row_q       <= row_d;
         sat_q       <= sat_d;
         out_valid_q <= (state_d == DRAIN);
         out_last_q  <= (state_d == DRAIN) && (row_d == LastRow);
         busy_q      <= (state_d != IDLE);
         cap_ready_q <= (state_d != DRAIN);
      end
   end

   assign cap_ready   = cap_ready_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign out_row_idx = row_q;
   assign out_row     = acc_q[row_q];
   assign sat_flag    = sat_q;
   assign busy        = busy_q;

endmodule
